// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register read/write request into the sequence of
// byte-controller commands for an I2C register access (device address,
// register address, then a data write or a repeated-start read). It handles
// slave NACK, arbitration loss and a per-command watchdog timeout.
module i2c_reg_seq #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
  input  logic       clk,
  input  logic       rst,
  // request / response
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  // byte controller
  output logic       bc_start,
  output logic       bc_stop,
  output logic       bc_read,
  output logic       bc_write,
  output logic       bc_ack_in,
  output logic [7:0] bc_din,
  input  logic       bc_cmd_ack,
  input  logic       bc_ack_out,
  input  logic [7:0] bc_dout,
  input  logic       bc_al
);

  typedef enum logic [2:0] {
    IDLE, DEV_W, REG, WDAT, RDEV, RDAT, NSTOP, DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_AL      = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

  // One byte-controller command: control bits plus the byte to send.
  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  function automatic cmd_t mk_cmd(input logic start, input logic stop,
                                  input logic read, input logic write,
                                  input logic ack_in, input logic [7:0] din);
    cmd_t c;
    c.start  = start;
    c.stop   = stop;
    c.read   = read;
    c.write  = write;
    c.ack_in = ack_in;
    c.din    = din;
    return c;
  endfunction

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] wd_q, wd_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        waiting;

  // Next-state, next-command and response logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    cmd_d        = cmd_q;
    wd_d         = wd_q;
    rnw_d        = rnw_q;
    dev_d        = dev_q;
    reg_addr_d   = reg_addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    waiting      = (state_q != IDLE) && (state_q != DONE);

    if (waiting) wd_d = wd_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rnw_d      = req_rnw;
          dev_d      = req_dev;
          reg_addr_d = req_reg;
          wdata_d    = req_wdata;
          cmd_d      = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {req_dev, 1'b0});
          wd_d       = 16'd0;
          state_d    = DEV_W;
        end
      end

      DONE: state_d = IDLE;

      default: begin
        // Arbitration loss wins over a simultaneous cmd_ack; no stop is sent.
        if (bc_al) begin
          cmd_d        = '0;
          state_d      = DONE;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_AL;
        end else if (bc_cmd_ack) begin
          wd_d = 16'd0;
          case (state_q)
            DEV_W: begin
              if (bc_ack_out) begin
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                state_d = NSTOP;
              end else begin
                cmd_d   = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, reg_addr_q);
                state_d = REG;
              end
            end
            REG: begin
              if (bc_ack_out) begin
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                state_d = NSTOP;
              end else if (rnw_q) begin
                cmd_d   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev_q, 1'b1});
                state_d = RDEV;
              end else begin
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, wdata_q);
                state_d = WDAT;
              end
            end
            RDEV: begin
              if (bc_ack_out) begin
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                state_d = NSTOP;
              end else begin
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
                state_d = RDAT;
              end
            end
            WDAT: begin
              cmd_d        = '0;
              state_d      = DONE;
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_OK;
            end
            RDAT: begin
              cmd_d        = '0;
              state_d      = DONE;
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_OK;
              rsp_rdata_d  = bc_dout;
            end
            NSTOP: begin
              cmd_d        = '0;
              state_d      = DONE;
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_NACK;
            end
            default: state_d = IDLE;
          endcase
        end else if (wd_q == TIMEOUT_CYC - 16'd1) begin
          // The counter reaches TIMEOUT_CYC on this edge: give up.
          cmd_d        = '0;
          state_d      = DONE;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
        end
      end
    endcase
  end

  // State, command, watchdog and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      wd_q         <= 16'd0;
      // NOTE: the captured request fields are cleared too, so nothing
      // downstream ever sees uninitialised values after reset.
      rnw_q        <= 1'b0;
      dev_q        <= 7'd0;
      reg_addr_q   <= 8'd0;
      wdata_q      <= 8'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'd0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      wd_q         <= wd_d;
      rnw_q        <= rnw_d;
      dev_q        <= dev_d;
      reg_addr_q   <= reg_addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign bc_start   = cmd_q.start;
  assign bc_stop    = cmd_q.stop;
  assign bc_read    = cmd_q.read;
  assign bc_write   = cmd_q.write;
  assign bc_ack_in  = cmd_q.ack_in;
  assign bc_din     = cmd_q.din;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Testbench for i2c_reg_seq: directed register transactions against a
// transaction-level model of the expected command sequence and response.
module tb_i2c_reg_seq;

  localparam logic [15:0] TO = 16'd16;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  typedef enum int { EV_NONE, EV_NACK, EV_AL, EV_TIMEOUT, EV_RST } ev_e;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rnw = 1'b0;
  logic [6:0] req_dev = 7'd0;
  logic [7:0] req_reg = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0] bc_din;
  logic       bc_cmd_ack = 1'b0;
  logic       bc_ack_out = 1'b0;
  logic [7:0] bc_dout = 8'd0;
  logic       bc_al = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_seq #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read),
    .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
    .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout),
    .bc_al(bc_al)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model expectations for the current cycle.
  bit         chk_en = 1'b0;
  cmd_t       exp_cmd = '0;
  logic       exp_ready = 1'b1;
  logic       exp_rsp_valid = 1'b0;
  logic [7:0] exp_rdata = 8'd0;
  logic [1:0] exp_status = 2'b00;

  // Command on the bus at each cmd_ack/al the bench returned.
  cmd_t log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic cmd_t mk(input logic s, input logic p, input logic r,
                              input logic w, input logic a, input logic [7:0] d);
    cmd_t c;
    c.start = s; c.stop = p; c.read = r; c.write = w; c.ack_in = a; c.din = d;
    return c;
  endfunction

  function automatic cmd_t dut_cmd();
    return mk(bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("req_ready",  32'(req_ready),  32'(exp_ready));
      check("bc_start",   32'(bc_start),   32'(exp_cmd.start));
      check("bc_stop",    32'(bc_stop),    32'(exp_cmd.stop));
      check("bc_read",    32'(bc_read),    32'(exp_cmd.read));
      check("bc_write",   32'(bc_write),   32'(exp_cmd.write));
      check("bc_ack_in",  32'(bc_ack_in),  32'(exp_cmd.ack_in));
      if (exp_cmd.write) check("bc_din", 32'(bc_din), 32'(exp_cmd.din));
      check("rsp_valid",  32'(rsp_valid),  32'(exp_rsp_valid));
      check("rsp_status", 32'(rsp_status), 32'(exp_status));
      check("rsp_rdata",  32'(rsp_rdata),  32'(exp_rdata));
    end
  end

  task automatic finish_txn(input logic [1:0] st, input logic [7:0] rdat);
    exp_cmd       = '0;
    exp_rsp_valid = 1'b1;
    exp_status    = st;
    exp_rdata     = rdat;
    req_valid     = 1'b0;
    @(posedge clk) #1;
    exp_rsp_valid = 1'b0;
    exp_ready     = 1'b1;
  endtask

  // One register access. ev/ev_step/dly pick an unusual event at one command
  // step (counted from 0 = device address); other steps ack after base_dly.
  task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int ev_step, input ev_e ev, input int dly,
                         input int base_dly, input bit hold_valid);
    cmd_t plan[$];
    int   i;
    bit   in_nstop;
    bit   done;
    log_q = {};
    plan  = {};
    plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev, 1'b0}));
    plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rg));
    if (rnw) begin
      plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev, 1'b1}));
      plan.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00));
    end else begin
      plan.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, wd));
    end

    req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(posedge clk) #1;
    // Change the request fields so a late capture would show up.
    req_valid = hold_valid; req_rnw = ~rnw; req_dev = dev ^ 7'h7F;
    req_reg = ~rg; req_wdata = ~wd;
    exp_ready = 1'b0;
    exp_cmd   = plan[0];
    i = 0; in_nstop = 1'b0; done = 1'b0;

    while (!done) begin
      int d;
      d = (i == ev_step) ? dly : base_dly;
      if (i == ev_step && ev == EV_TIMEOUT) begin
        repeat (int'(TO)) @(posedge clk) #1;
        finish_txn(2'b11, exp_rdata);
        done = 1'b1;
      end else begin
        repeat (d) @(posedge clk) #1;
        if (i == ev_step && ev == EV_RST) begin
          rst = 1'b1;
          @(posedge clk) #1;
          rst = 1'b0;
          req_valid = 1'b0;
          exp_cmd = '0; exp_ready = 1'b1; exp_rsp_valid = 1'b0;
          exp_rdata = 8'd0; exp_status = 2'b00;
          return;
        end
        log_q.push_back(dut_cmd());
        if (i == ev_step && ev == EV_AL) bc_al = 1'b1;
        else begin
          bc_cmd_ack = 1'b1;
          bc_ack_out = (i == ev_step && ev == EV_NACK);
          bc_dout    = (!in_nstop && i == plan.size() - 1) ? rd : 8'hEE;
        end
        @(posedge clk) #1;
        bc_cmd_ack = 1'b0; bc_al = 1'b0; bc_ack_out = 1'b0; bc_dout = 8'h00;
        if (i == ev_step && ev == EV_AL) begin
          finish_txn(2'b10, exp_rdata); done = 1'b1;
        end else if (in_nstop) begin
          finish_txn(2'b01, exp_rdata); done = 1'b1;
        end else if (i == plan.size() - 1) begin
          finish_txn(2'b00, rnw ? rd : exp_rdata); done = 1'b1;
        end else if (i == ev_step && ev == EV_NACK) begin
          in_nstop = 1'b1;
          exp_cmd  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end else begin
          i++;
          exp_cmd = plan[i];
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset_ready",  32'(req_ready),  32'd1);
    check("reset_cmd",    32'(dut_cmd()),  32'd0);
    check("reset_valid",  32'(rsp_valid),  32'd0);
    check("reset_status", 32'(rsp_status), 32'd0);
    @(posedge clk) #1;

    // Plain write, all bytes acked.
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, EV_NONE, 0, 1, 1'b0);
    check("wr_len", 32'(log_q.size()), 32'd3);
    check("wr_b0",  32'(log_q[0]), 32'(13'b1_0_0_1_0_1010_0000));
    check("wr_b1",  32'(log_q[1]), 32'(13'b0_0_0_1_0_0001_0000));
    check("wr_b2",  32'(log_q[2]), 32'(13'b0_1_0_1_0_1010_0101));
    check("wr_status", 32'(rsp_status), 32'd0);

    // Plain read at minimum latency.
    run_txn(1'b1, 7'h50, 8'h02, 8'h00, 8'h3C, -1, EV_NONE, 0, 0, 1'b0);
    check("rd_len",  32'(log_q.size()), 32'd4);
    check("rd_b0",   32'(log_q[0].din), 32'hA0);
    check("rd_b1",   32'(log_q[1].din), 32'h02);
    check("rd_b2",   32'(log_q[2]), 32'(13'b1_0_0_1_0_1010_0001));
    check("rd_b3",   32'(log_q[3][12:8]), 32'(5'b01101));
    check("rd_data", 32'(rsp_rdata), 32'h3C);
    check("rd_status", 32'(rsp_status), 32'd0);

    // NACK on the device address of a write: stop only, REG never issued.
    run_txn(1'b0, 7'h22, 8'h33, 8'h44, 8'h00, 0, EV_NACK, 2, 1, 1'b0);
    check("nack_len",    32'(log_q.size()), 32'd2);
    check("nack_stop",   32'(log_q[1][12:8]), 32'(5'b01000));
    check("nack_status", 32'(rsp_status), 32'd1);
    check("nack_rdata_hold", 32'(rsp_rdata), 32'h3C);

    // NACKs on register address and on the repeated-start address of a read.
    run_txn(1'b1, 7'h11, 8'h5A, 8'h00, 8'h99, 1, EV_NACK, 0, 0, 1'b0);
    run_txn(1'b1, 7'h6B, 8'hC3, 8'h00, 8'h99, 2, EV_NACK, 3, 1, 1'b0);

    // ack_out is ignored after the data phases.
    run_txn(1'b0, 7'h3F, 8'h80, 8'h01, 8'h00, 2, EV_NACK, 1, 0, 1'b0);
    run_txn(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h81, 3, EV_NACK, 0, 2, 1'b0);
    check("rd_nack_ignored_data", 32'(rsp_rdata), 32'h81);

    // Arbitration loss during REG, in DEV_W and in RDAT.
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, EV_AL, 2, 0, 1'b0);
    check("al_status", 32'(rsp_status), 32'd2);
    check("al_ready",  32'(req_ready), 32'd1);
    run_txn(1'b0, 7'h01, 8'h02, 8'h03, 8'h00, 0, EV_AL, 0, 0, 1'b0);
    run_txn(1'b1, 7'h01, 8'h02, 8'h00, 8'h55, 3, EV_AL, 1, 0, 1'b0);

    // Watchdog expiry on the first command and on RDAT.
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, EV_TIMEOUT, 0, 0, 1'b0);
    check("to_status", 32'(rsp_status), 32'd3);
    run_txn(1'b1, 7'h50, 8'h02, 8'h00, 8'h00, 3, EV_TIMEOUT, 0, 3, 1'b0);

    // req_valid held high while busy: no extra acceptance, fields not recaptured.
    run_txn(1'b0, 7'h2A, 8'h44, 8'h66, 8'h00, -1, EV_NONE, 0, 2, 1'b1);

    // Reset in the middle of RDAT, then a normal transaction.
    run_txn(1'b1, 7'h50, 8'h02, 8'h00, 8'h3C, 3, EV_RST, 2, 0, 1'b0);
    check("mid_rst_cmd",   32'(dut_cmd()),  32'd0);
    check("mid_rst_valid", 32'(rsp_valid),  32'd0);
    check("mid_rst_rdata", 32'(rsp_rdata),  32'd0);
    repeat (3) @(posedge clk) #1;
    run_txn(1'b1, 7'h12, 8'h34, 8'h00, 8'h5E, -1, EV_NONE, 0, 1, 1'b0);
    check("post_rst_data", 32'(rsp_rdata), 32'h5E);

    repeat (2) @(posedge clk) #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16'd65535, maximum clk cycles to wait for each byte-controller cmd_ack.
REQ-002 clk  in  1  master clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  register-access request present.
REQ-005 req_ready  out  1  sequencer idle and accepting a request.
REQ-006 req_rnw  in  1  1=register read, 0=register write.
REQ-007 req_dev  in  7  7-bit I2C device address.
REQ-008 req_reg  in  8  register address.
REQ-009 req_wdata  in  8  write data (ignored for reads).
REQ-010 rsp_valid  out  1  one-cycle pulse, transaction finished.
REQ-011 rsp_rdata  out  8  read data, valid with rsp_valid when status=00.
REQ-012 rsp_status  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout.
REQ-013 bc_start, bc_stop, bc_read, bc_write  out  1 each  byte-controller command bits.
REQ-014 bc_ack_in  out  1  master ACK level for reads (1=NACK).
REQ-015 bc_din  out  8  byte to transmit.
REQ-016 bc_cmd_ack  in  1  byte-controller command-done pulse.
REQ-017 bc_ack_out  in  1  slave ACK bit after a write (1=NACK).
REQ-018 bc_dout  in  8  received byte.
REQ-019 bc_al  in  1  arbitration-lost flag.

Function
REQ-020 Request accepted on clk edge with req_valid & req_ready; req_dev/req_reg/req_wdata/req_rnw captured into internal registers at that edge.
REQ-021 req_ready is 1 only in state IDLE.
REQ-022 States: IDLE, DEV_W, REG, WDAT, RDEV, RDAT, NSTOP, DONE.
REQ-023 Command bits are registered, presented the cycle after acceptance or after the previous cmd_ack, held stable until bc_cmd_ack, and all cleared in the cmd_ack cycle unless the next command is loaded that edge.
REQ-024 DEV_W: bc_start=1, bc_write=1, bc_din={dev,1'b0}.
REQ-025 REG: bc_write=1, bc_din=reg.
REQ-026 WDAT (write only): bc_write=1, bc_stop=1, bc_din=wdata; cmd_ack -> DONE status 00.
REQ-027 RDEV (read only, repeated start): bc_start=1, bc_write=1, bc_din={dev,1'b1}.
REQ-028 RDAT: bc_read=1, bc_ack_in=1, bc_stop=1; on cmd_ack capture bc_dout into rsp_rdata -> DONE status 00.
REQ-029 After cmd_ack in DEV_W, REG or RDEV, bc_ack_out=1 -> NSTOP (bc_stop=1 only, other command bits 0); its cmd_ack -> DONE status 01.
REQ-030 bc_ack_out is ignored after WDAT and RDAT commands.
REQ-031 bc_al=1 in any non-IDLE state -> all command bits cleared next edge, no stop issued, DONE status 10; bc_al has priority over bc_cmd_ack in the same cycle.
REQ-032 Watchdog: 16-bit counter cleared on each command load, increments while waiting; reaching TIMEOUT_CYC -> command bits cleared, DONE status 11.
REQ-033 DONE: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata and rsp_status hold until the next rsp_valid.
REQ-034 Requests arriving while req_ready=0 are not accepted; no queuing.
REQ-035 Minimum latency acceptance -> rsp_valid: write = 3 cmd_acks + 1 cycle; read = 4 cmd_acks + 1 cycle.

Reset
REQ-036 rst=1 at any edge -> next state IDLE; all bc_* command bits, bc_ack_in, bc_din, rsp_valid, rsp_rdata, rsp_status, watchdog = 0; req_ready=1 from the first cycle after rst deasserts.
REQ-037 Reset mid-transaction aborts silently: no STOP issued, no rsp_valid.

Verification
REQ-038 Write dev=0x50 reg=0x10 data=0xA5, slave ACKs all bytes -> bc_din sequence 0xA0, 0x10, 0xA5; stop only with the third byte; rsp_status=00.
REQ-039 Read dev=0x50 reg=0x02, slave returns 0x3C -> bc_din 0xA0, 0x02, 0xA1 (second start), read with ack_in=1 + stop; rsp_rdata=0x3C, status 00.
REQ-040 Write with bc_ack_out=1 after the address byte -> next command is stop-only; rsp_status=01; REG never issued.
REQ-041 bc_al pulse during REG -> command bits 0 next cycle; rsp_valid with status 10; req_ready=1 the following cycle.
REQ-042 TIMEOUT_CYC=16 and cmd_ack withheld -> rsp_valid with status 11 at 16 cycles after command load.
REQ-043 rst asserted during RDAT -> all outputs 0 next cycle, no rsp_valid; a new request is accepted normally afterwards.
